// File: rtl/alu_core.sv
// Registered integer ALU (add/sub/logic/slt) with Zero/Negative/Carry/Overflow flags.
// Optional macro ALU_SHIFT_EN turns reserved codes 110/111 into SLL/SRL.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             valid_out,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic             w_sub;
  logic             w_arith;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;

  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  // Shared adder and result/flag selection
  always_comb begin
    w_sub    = (ALUControl == 3'b001) || (ALUControl == 3'b101);
    w_arith  = (ALUControl == 3'b000) || w_sub;
    w_b_eff  = B ^ {WIDTH{w_sub}};
    w_sum    = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    // Same-sign inputs to the adder producing a different-sign sum
    w_ovf    = (A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    w_lt     = w_sum[WIDTH-1] ^ w_ovf;
    w_result = {WIDTH{1'b0}};
    case (ALUControl)
      3'b000:  w_result = w_sum[WIDTH-1:0];
      3'b001:  w_result = w_sum[WIDTH-1:0];
      3'b010:  w_result = A & B;
      3'b011:  w_result = A | B;
      3'b100:  w_result = A ^ B;
      3'b101:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_SHIFT_EN
      3'b110:  w_result = A << B[SHW-1:0];
      3'b111:  w_result = A >> B[SHW-1:0];
`else
      3'b110:  w_result = {WIDTH{1'b0}};
      3'b111:  w_result = {WIDTH{1'b0}};
`endif
      default: w_result = {WIDTH{1'b0}};
    endcase
  end

  // Output registers: sync reset, update on valid, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= {WIDTH{1'b0}};
      r_valid  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_result <= w_result;
        r_zero   <= (w_result == {WIDTH{1'b0}});
        r_neg    <= w_result[WIDTH-1];
        r_carry  <= w_arith & w_sum[WIDTH];
        r_ovf    <= w_arith & w_ovf;
      end else begin
        r_result <= r_result;
        r_zero   <= r_zero;
        r_neg    <= r_neg;
        r_carry  <= r_carry;
        r_ovf    <= r_ovf;
      end
    end
  end

  assign Result    = r_result;
  assign valid_out = r_valid;
  assign Zero      = r_zero;
  assign Negative  = r_neg;
  assign Carry     = r_carry;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core (WIDTH=32); expectations follow ALU_SHIFT_EN.
module tb_alu_core;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUControl;
  logic [31:0] Result;
  logic        valid_out;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        Overflow;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t last;

  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .A(A), .B(B),
    .ALUControl(ALUControl), .Result(Result), .valid_out(valid_out),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  function automatic logic ovf_chk(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [32:0] u;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      3'd0: begin u = {1'b0, a} + {1'b0, b}; e.r = u[31:0]; e.c = u[32]; e.v = ovf_chk(sa + sb); end
      3'd1: begin e.r = a - b; e.c = (a >= b); e.v = ovf_chk(sa - sb); end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: begin e.r = (sa < sb) ? 32'd1 : 32'd0; e.c = (a >= b); e.v = ovf_chk(sa - sb); end
`ifdef ALU_SHIFT_EN
      3'd6: e.r = a << b[4:0];
      3'd7: e.r = a >> b[4:0];
`endif
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  function automatic logic [63:0] observed();
    return {27'd0, valid_out, Zero, Negative, Carry, Overflow, Result};
  endfunction

  function automatic logic [63:0] pack(input logic v, input exp_t e);
    return {27'd0, v, e.z, e.n, e.c, e.v, e.r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    exp_t e;
    A = a; B = b; ALUControl = c; valid_in = 1'b1;
    q.push_back(model(a, b, c));
    @(posedge clk); #1;
    if (q.size() == 0) begin
      check({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      e    = q.pop_front();
      last = e;
      check(tag, observed(), pack(1'b1, e));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0; A = $urandom; B = $urandom; ALUControl = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      check("hold", observed(), pack(1'b0, last));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b1; A = 32'h1234_5678; B = 32'h0000_0001; ALUControl = 3'b000;
    last = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset", observed(), 64'd0);
    end
    rst_n = 1'b1;
    do_op("add_aa55", 32'hAAAA_AAAA, 32'h5555_5555, 3'b000);
    do_op("sub_aa55", 32'hAAAA_AAAA, 32'h5555_5555, 3'b001);
    do_op("slt_aa55", 32'hAAAA_AAAA, 32'h5555_5555, 3'b101);
    do_op("and_aa55", 32'hAAAA_AAAA, 32'h5555_5555, 3'b010);
    do_op("or_aa55",  32'hAAAA_AAAA, 32'h5555_5555, 3'b011);
    do_op("xor_aa55", 32'hAAAA_AAAA, 32'h5555_5555, 3'b100);
    do_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 3'b000);
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
    idle(3);
    do_op("op110",    32'h0000_0001, 32'h0000_0004, 3'b110);
    do_op("op111",    32'h8000_0000, 32'hFFFF_FFE4, 3'b111);
    do_op("sub_eq",   32'h0000_0007, 32'h0000_0007, 3'b001);
    do_op("sub_brw",  32'h0000_0001, 32'h0000_0002, 3'b001);
    do_op("slt_ovf",  32'h8000_0000, 32'h0000_0001, 3'b101);
    do_op("slt_pos",  32'h7FFF_FFFF, 32'h8000_0000, 3'b101);
    do_op("sub_ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b001);
    for (int i = 0; i < 60; i++) begin
      do_op("rand", $urandom, $urandom, 3'($urandom_range(0, 7)));
    end
    idle(2);
    rst_n = 1'b0; valid_in = 1'b1; A = 32'hFFFF_FFFF; B = 32'h1; ALUControl = 3'b000;
    @(posedge clk); #1;
    check("reset_prio", observed(), 64'd0);
    rst_n = 1'b1;
    do_op("after_rst", 32'h0000_0003, 32'h0000_0004, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
